vote_tally: RTL and testbench
=============================

# vote_tally

Parametrised ballot-counting engine for the voting system: tallies one-hot ballots for `NCAND` candidates through a valid/ready handshake, then sequentially scans the tallies to produce the maximum count, a multi-hot winner mask and a tie flag. It generalises the fixed five-candidate counter-plus-comparator-tree machine. It adds a session state machine, saturating counters, rejection of malformed ballots and a registered, held result.

## Interface
Parameters:
- `NCAND`, 5, number of candidates, at least 2
- `CW`, 32, width of each tally counter, at least 2

Ports:
- `clk`  in  1  single clock; all state updates on posedge
- `rst`  in  1  reset is synchronous and active-high
- `start`  in  1  opens a new voting session; clears tallies
- `close`  in  1  ends the session; starts the winner scan
- `ballot`  in  NCAND  ballot vector; bit i is a vote for candidate i
- `ballot_valid`  in  1  `ballot` is presented
- `ballot_ready`  out  1  block accepts ballots; high only in OPEN
- `busy`  out  1  high in SCAN
- `done`  out  1  high in DONE; results valid
- `counts`  out  NCAND*CW  live tallies; candidate i at bits [i*CW +: CW]
- `win_num`  out  CW  maximum tally
- `win`  out  NCAND  winner mask; bit i set if candidate i holds the maximum
- `tie`  out  1  more than one bit of `win` is set
- `total`  out  CW  accepted valid ballots (audit)
- `rejected`  out  CW  accepted malformed ballots (audit)

## Operation
States are IDLE, OPEN, SCAN and DONE. Reset enters IDLE.

- **IDLE:** `ballot_ready`=0. When `start`=1:
  - clear all tallies, `total`, `rejected`, `win`, `win_num` and `tie`
  - go to OPEN
- **OPEN:** `ballot_ready`=1. A ballot is accepted when `ballot_valid` and `ballot_ready` are both high.
  - Exactly one bit set: that candidate's tally +1, `total` +1.
  - Zero bits or more than one bit set: `rejected` +1; no tally changes.
  - `close`=1: go to SCAN. A ballot accepted in the same cycle as `close` is counted.
  - `start` is ignored while in OPEN.
- **SCAN:** one candidate per cycle, index 0 to NCAND-1, using a running max `m` and mask `k`.
  - Index 0: `m`=tally[0], `k`=1<<0.
  - Index i: if tally[i] > `m`, then `m`=tally[i] and `k`=1<<i. If tally[i] == `m`, then `k` |= 1<<i.
  - After index NCAND-1: load `win_num`=`m`, `win`=`k`, `tie`=(popcount(`k`) > 1), and go to DONE.
  - `start`, `close` and ballots are ignored.
- **DONE:** results and tallies are held. `start`=1 clears everything as in IDLE and goes to OPEN. `close` is ignored.
- **Arithmetic:**
  - All counters saturate at 2^CW-1; an increment at the maximum leaves the value unchanged.
  - Comparisons are unsigned, CW bits.
  - Multiple candidates at saturation are reported as a tie.
- **All tallies zero at close:** `win_num`=0, `win`=all ones, `tie`=1.

## Timing
- **Reset values:** state IDLE, `ballot_ready`=0, `busy`=0, `done`=0, and `counts`, `win_num`, `win`, `tie`, `total`, `rejected` all 0.
- **Reset mid-session or mid-scan:** next state IDLE with all outputs at reset values. `rst` has priority over `start` and `close`.
- **Handshake:** `ballot_ready` is a registered function of state. A ballot counts at the same edge that samples `ballot_valid`&&`ballot_ready`, and the new tally is visible on `counts` the cycle after.
- **Session start:** `start` sampled at edge E makes `ballot_ready`=1 and zeroed `counts` visible after E.
- **Scan latency:** `close` sampled at edge E0 puts the block in SCAN after E0 (`busy`=1, `ballot_ready`=0). Edges E1..E_NCAND process indices 0..NCAND-1, and `done`=1 with valid results after E_NCAND. For NCAND=5 that is 6 edges from close to done.
- **Result outputs:** `win`, `win_num` and `tie` change only on entry to DONE or when cleared by `start`/`rst`; outside DONE they read 0.

## Configuration
- **`VOTE_AUDIT_EN` defined:**
  - `total` and `rejected` count as described and saturate at 2^CW-1.
- **`VOTE_AUDIT_EN` undefined:**
  - The audit counters are not built; `total` and `rejected` are tied to 0.
  - Malformed ballots are still accepted and dropped without changing any tally.
  - All other behaviour and timing are identical.

## Test plan
- Reset, then `start`, then 3 ballots for candidate 1 and 2 for candidate 3, then `close`:
  - tallies {0,3,0,2,0}
  - `done` exactly 6 edges after the close edge
  - `win`=5'b00010, `win_num`=3, `tie`=0
- Ballots 5'b00011 and 5'b00000 in OPEN:
  - tallies unchanged
  - with `VOTE_AUDIT_EN`: `rejected`=2, `total`=0
- 2 votes each for candidates 0 and 4, then `close`: `win`=5'b10001, `win_num`=2, `tie`=1.
- `close` with no votes: `win`=5'b11111, `win_num`=0, `tie`=1.
- CW=2, 5 votes for candidate 2: tally saturates at 3; `win_num`=3.
- Each of these leaves all outputs at reset values and the state in IDLE:
  - `rst` during SCAN, followed by `close`
  - `ballot_valid` while in IDLE
  - a second `start` after DONE, which instead clears the results and tallies and reopens the session

Source files
------------

// File: rtl/vote_tally_if.sv
// vote_tally_if: ballot handshake, session control and result bus for vote_tally.
// The master side (the voting front end) drives the controls and ballots; the slave side
// (vote_tally) returns the tallies, the results and the audit counters.
interface vote_tally_if #(
  parameter int unsigned NCAND = 5,
  parameter int unsigned CW    = 32
);
  logic                start;
  logic                close;
  logic [NCAND-1:0]    ballot;
  logic                ballot_valid;
  logic                ballot_ready;
  logic                busy;
  logic                done;
  logic [NCAND*CW-1:0] counts;
  logic [CW-1:0]       win_num;
  logic [NCAND-1:0]    win;
  logic                tie;
  logic [CW-1:0]       total;
  logic [CW-1:0]       rejected;

  modport master (
    output start, close, ballot, ballot_valid,
    input  ballot_ready, busy, done, counts, win_num, win, tie, total, rejected
  );

  modport slave (
    input  start, close, ballot, ballot_valid,
    output ballot_ready, busy, done, counts, win_num, win, tie, total, rejected
  );
endinterface

// File: rtl/vote_tally.sv
// vote_tally: session-based ballot counter with a sequential winner scan.
// The IDLE -> OPEN -> SCAN -> DONE session accepts one-hot ballots into saturating tallies.
// It scans one candidate per cycle and holds the maximum, the winner mask and the tie flag.
// Define VOTE_AUDIT_EN to build the saturating total/rejected audit counters. When it is
// undefined, total and rejected read 0.
module vote_tally #(
  parameter int unsigned NCAND = 5,
  parameter int unsigned CW    = 32
) (
  input  logic           clk,
  input  logic           rst,
  vote_tally_if.slave    bus
);
  localparam int unsigned IW = (NCAND > 1) ? $clog2(NCAND) : 1;

  typedef enum logic [1:0] {IDLE, OPEN, SCAN, DONE} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    tally_q [NCAND];
  logic [CW-1:0]    tally_d [NCAND];
  logic [IW-1:0]    idx_q, idx_d;
  logic [CW-1:0]    m_q, m_d;
  logic [NCAND-1:0] k_q, k_d;
  logic [CW-1:0]    win_num_q, win_num_d;
  logic [NCAND-1:0] win_q, win_d;
  logic             tie_q, tie_d;

  logic             accept;
  logic             well_formed;
  logic             clr;
  logic [CW-1:0]    cur;
  logic [CW-1:0]    m_scan;
  logic [NCAND-1:0] k_scan;

  // Ballot acceptance and one-hot qualification
  always_comb begin
    accept      = bus.ballot_valid && (state_q == OPEN);
    well_formed = (bus.ballot != '0) && ((bus.ballot & (bus.ballot - NCAND'(1))) == '0);
  end

  // Session FSM next state, tally updates and scan step
  always_comb begin
    state_d   = state_q;
    tally_d   = tally_q;
    idx_d     = idx_q;
    m_d       = m_q;
    k_d       = k_q;
    win_num_d = win_num_q;
    win_d     = win_q;
    tie_d     = tie_q;
    clr       = 1'b0;
    cur       = tally_q[idx_q];
    m_scan    = m_q;
    k_scan    = k_q;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          clr     = 1'b1;
          state_d = OPEN;
        end
      end
      OPEN: begin
        if (accept && well_formed) begin
          for (int unsigned i = 0; i < NCAND; i++) begin
            if (bus.ballot[i] && (tally_q[i] != '1)) tally_d[i] = tally_q[i] + CW'(1);
          end
        end
        if (bus.close) begin
          state_d = SCAN;
          idx_d   = '0;
        end
      end
      SCAN: begin
        if (idx_q == '0) begin
          m_scan = cur;
          k_scan = NCAND'(1);
        end else if (cur > m_q) begin
          m_scan = cur;
          k_scan = NCAND'(1) << idx_q;
        end else if (cur == m_q) begin
          k_scan = k_q | (NCAND'(1) << idx_q);
        end
        m_d   = m_scan;
        k_d   = k_scan;
        idx_d = idx_q + IW'(1);
        if (idx_q == IW'(NCAND - 1)) begin
          win_num_d = m_scan;
          win_d     = k_scan;
          tie_d     = (k_scan & (k_scan - NCAND'(1))) != '0;
          state_d   = DONE;
        end
      end
      DONE: begin
        if (bus.start) begin
          clr     = 1'b1;
          state_d = OPEN;
        end
      end
      default: state_d = IDLE;
    endcase
    if (clr) begin
      for (int unsigned i = 0; i < NCAND; i++) tally_d[i] = '0;
      win_num_d = '0;
      win_d     = '0;
      tie_d     = 1'b0;
    end
  end

  // State, tally and result registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      for (int unsigned i = 0; i < NCAND; i++) tally_q[i] <= '0;
      idx_q     <= '0;
      m_q       <= '0;
      k_q       <= '0;
      win_num_q <= '0;
      win_q     <= '0;
      tie_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      tally_q   <= tally_d;
      idx_q     <= idx_d;
      m_q       <= m_d;
      k_q       <= k_d;
      win_num_q <= win_num_d;
      win_q     <= win_d;
      tie_q     <= tie_d;
    end
  end

`ifdef VOTE_AUDIT_EN
  logic [CW-1:0] total_q, total_d;
  logic [CW-1:0] rejected_q, rejected_d;

  // Audit counter next state: saturating valid/malformed ballot counts
  always_comb begin
    total_d    = total_q;
    rejected_d = rejected_q;
    if (clr) begin
      total_d    = '0;
      rejected_d = '0;
    end else if (accept) begin
      if (well_formed) begin
        if (total_q != '1) total_d = total_q + CW'(1);
      end else begin
        if (rejected_q != '1) rejected_d = rejected_q + CW'(1);
      end
    end
  end

  // Audit counter registers
  always_ff @(posedge clk) begin
    if (rst) begin
      total_q    <= '0;
      rejected_q <= '0;
    end else begin
      total_q    <= total_d;
      rejected_q <= rejected_d;
    end
  end

  assign bus.total    = total_q;
  assign bus.rejected = rejected_q;
`else
  assign bus.total    = '0;
  assign bus.rejected = '0;
`endif

  assign bus.ballot_ready = (state_q == OPEN);
  assign bus.busy         = (state_q == SCAN);
  assign bus.done         = (state_q == DONE);
  assign bus.win_num      = win_num_q;
  assign bus.win          = win_q;
  assign bus.tie          = tie_q;

  for (genvar g = 0; g < NCAND; g++) begin : g_counts
    assign bus.counts[g*CW +: CW] = tally_q[g];
  end
endmodule

// File: tb/tb_vote_tally.sv
// tb_vote_tally: directed checks of vote_tally with a 32-bit instance and a 2-bit saturation instance.
module tb_vote_tally;
  localparam int unsigned NC  = 5;
  localparam int unsigned CW  = 32;
  localparam int unsigned CW2 = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  vote_tally_if #(.NCAND(NC), .CW(CW))  bus  ();
  vote_tally_if #(.NCAND(NC), .CW(CW2)) bus2 ();

  vote_tally #(.NCAND(NC), .CW(CW))  dut  (.clk(clk), .rst(rst), .bus(bus));
  vote_tally #(.NCAND(NC), .CW(CW2)) dut2 (.clk(clk), .rst(rst), .bus(bus2));

  int unsigned checks = 0;
  int unsigned passes = 0;
  int unsigned fails  = 0;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic vote(input logic [NC-1:0] b);
    bus.ballot       = b;
    bus.ballot_valid = 1'b1;
    tick();
    bus.ballot_valid = 1'b0;
    bus.ballot       = '0;
  endtask

  task automatic vote2(input logic [NC-1:0] b);
    bus2.ballot       = b;
    bus2.ballot_valid = 1'b1;
    tick();
    bus2.ballot_valid = 1'b0;
    bus2.ballot       = '0;
  endtask

  task automatic do_start;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  // Counts edges from the close edge (inclusive) until done, bounded.
  task automatic close_wait(output int n);
    bus.close = 1'b1;
    tick();
    bus.close = 1'b0;
    n = 1;
    while (bus.done !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
  endtask

  initial begin
    int n;
    logic [NC*CW-1:0]  exp_counts;
    logic [NC*CW2-1:0] exp_counts2;
    logic [CW-1:0]     exp_total, exp_rej;
    logic [CW2-1:0]    exp_total2;

    bus.start = 1'b0;  bus.close = 1'b0;  bus.ballot = '0;  bus.ballot_valid = 1'b0;
    bus2.start = 1'b0; bus2.close = 1'b0; bus2.ballot = '0; bus2.ballot_valid = 1'b0;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;

    // Reset state
    chk("rst_ready",   256'(bus.ballot_ready), 256'(0));
    chk("rst_busy",    256'(bus.busy),         256'(0));
    chk("rst_done",    256'(bus.done),         256'(0));
    chk("rst_counts",  256'(bus.counts),       256'(0));
    chk("rst_win_num", 256'(bus.win_num),      256'(0));
    chk("rst_win",     256'(bus.win),          256'(0));
    chk("rst_tie",     256'(bus.tie),          256'(0));
    chk("rst_total",   256'(bus.total),        256'(0));
    chk("rst_rej",     256'(bus.rejected),     256'(0));

    // Ballot in IDLE is ignored
    vote(5'b00010);
    chk("idle_counts", 256'(bus.counts),       256'(0));
    chk("idle_ready",  256'(bus.ballot_ready), 256'(0));
    chk("idle_total",  256'(bus.total),        256'(0));

    // Session 1: 3 votes for cand 1, 2 for cand 3, plus two malformed ballots
    do_start();
    chk("s1_ready",  256'(bus.ballot_ready), 256'(1));
    chk("s1_counts0", 256'(bus.counts),      256'(0));
    vote(5'b00010); vote(5'b00010); vote(5'b00010);
    vote(5'b01000); vote(5'b01000);
    vote(5'b00011); vote(5'b00000);
    exp_counts = '0;
    exp_counts[1*CW +: CW] = CW'(3);
    exp_counts[3*CW +: CW] = CW'(2);
`ifdef VOTE_AUDIT_EN
    exp_total = CW'(5);
    exp_rej   = CW'(2);
`else
    exp_total = '0;
    exp_rej   = '0;
`endif
    chk("s1_counts", 256'(bus.counts),   256'(exp_counts));
    chk("s1_total",  256'(bus.total),    256'(exp_total));
    chk("s1_rej",    256'(bus.rejected), 256'(exp_rej));
    chk("s1_win_pre", 256'(bus.win),     256'(0));
    close_wait(n);
    chk("s1_latency", 256'(n),           256'(6));
    chk("s1_win",     256'(bus.win),     256'(5'b00010));
    chk("s1_win_num", 256'(bus.win_num), 256'(3));
    chk("s1_tie",     256'(bus.tie),     256'(0));
    chk("s1_hold",    256'(bus.counts),  256'(exp_counts));
    bus.close = 1'b1;
    tick();
    bus.close = 1'b0;
    chk("s1_close_in_done", 256'(bus.done), 256'(1));

    // Second start after DONE clears and reopens
    do_start();
    chk("s2_ready",   256'(bus.ballot_ready), 256'(1));
    chk("s2_done",    256'(bus.done),         256'(0));
    chk("s2_counts",  256'(bus.counts),       256'(0));
    chk("s2_win",     256'(bus.win),          256'(0));
    chk("s2_win_num", 256'(bus.win_num),      256'(0));
    chk("s2_total",   256'(bus.total),        256'(0));

    // Tie between cand 0 and 4; last ballot arrives with close
    vote(5'b00001); vote(5'b10000); vote(5'b00001);
    bus.ballot = 5'b10000;
    bus.ballot_valid = 1'b1;
    close_wait(n);
    bus.ballot_valid = 1'b0;
    bus.ballot = '0;
    chk("s2_latency", 256'(n),           256'(6));
    chk("s2_win",     256'(bus.win),     256'(5'b10001));
    chk("s2_win_num", 256'(bus.win_num), 256'(2));
    chk("s2_tie",     256'(bus.tie),     256'(1));

    // No votes at all
    do_start();
    close_wait(n);
    chk("s3_win",     256'(bus.win),     256'(5'b11111));
    chk("s3_win_num", 256'(bus.win_num), 256'(0));
    chk("s3_tie",     256'(bus.tie),     256'(1));

    // Reset during SCAN, then close in IDLE
    do_start();
    vote(5'b00001);
    bus.close = 1'b1;
    tick();
    bus.close = 1'b0;
    chk("s4_busy", 256'(bus.busy), 256'(1));
    tick();
    rst = 1'b1;
    bus.close = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    bus.close = 1'b0;
    chk("s4_ready",   256'(bus.ballot_ready), 256'(0));
    chk("s4_busy0",   256'(bus.busy),         256'(0));
    chk("s4_done",    256'(bus.done),         256'(0));
    chk("s4_counts",  256'(bus.counts),       256'(0));
    chk("s4_win",     256'(bus.win),          256'(0));
    chk("s4_win_num", 256'(bus.win_num),      256'(0));
    chk("s4_total",   256'(bus.total),        256'(0));

    // CW=2 saturation: cand 2 gets 5 votes, cand 0 gets 3, both saturate at 3
    bus2.start = 1'b1;
    tick();
    bus2.start = 1'b0;
    for (int i = 0; i < 5; i++) vote2(5'b00100);
    for (int i = 0; i < 3; i++) vote2(5'b00001);
    exp_counts2 = '0;
    exp_counts2[0*CW2 +: CW2] = CW2'(3);
    exp_counts2[2*CW2 +: CW2] = CW2'(3);
`ifdef VOTE_AUDIT_EN
    exp_total2 = CW2'(3);
`else
    exp_total2 = '0;
`endif
    chk("sat_counts", 256'(bus2.counts), 256'(exp_counts2));
    chk("sat_total",  256'(bus2.total),  256'(exp_total2));
    bus2.close = 1'b1;
    tick();
    bus2.close = 1'b0;
    n = 1;
    while (bus2.done !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    chk("sat_latency", 256'(n),            256'(6));
    chk("sat_win_num", 256'(bus2.win_num), 256'(3));
    chk("sat_win",     256'(bus2.win),     256'(5'b00101));
    chk("sat_tie",     256'(bus2.tie),     256'(1));

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
